// File: rtl/ascon_round_feeder_if.sv
// Shared ASCON state type and the handshake/data bundle between the round
// feeder and its environment. The slave modport is the feeder's view.
package ascon_pack;
  // Word 0 is the leftmost element, so {x0, x1, x2, x3, x4} maps to s[0]..s[4]
  typedef logic [0:4][63:0] type_state;
endpackage

interface ascon_round_feeder_if;
  import ascon_pack::*;

  logic       start_i;
  logic       mode_i;
  type_state  state_i;
  type_state  feedback_i;
  type_state  state_o;
  type_state  result_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, mode_i, state_i, feedback_i,
    input  state_o, result_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, state_i, feedback_i,
    output state_o, result_o, round_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_round_feeder.sv
// Round-control stage ahead of the ASCON substitution layer: holds the state
// and round counter, adds the round constant, and loops p12 or p6.
module ascon_round_feeder
  import ascon_pack::*;
(
  input  logic                 clock_i,
  input  logic                 reset_i,
  ascon_round_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] round_const;

  // (15 - r) in the high nibble equals the bitwise complement of r
  assign round_const = {~round_q, round_q};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_state_out
      if (gi == 2) begin : g_const_word
        assign bus.state_o[gi] = state_q[gi] ^ {56'h0, round_const};
      end else begin : g_plain_word
        assign bus.state_o[gi] = state_q[gi];
      end
    end
  endgenerate

  assign bus.result_o = state_q;
  assign bus.round_o  = round_q;
  assign bus.busy_o   = (fsm_q == RUN);
  assign bus.done_o   = (fsm_q == DONE);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          round_d = bus.mode_i ? 4'd6 : 4'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = bus.feedback_i;
        // The counter parks on 11 so DONE still shows the last round index
        if (round_q == 4'd11) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_ascon_round_feeder.sv
// Bench for ascon_round_feeder: closes the round loop with either an identity
// path or a software ASCON round, and scoreboards results at each done pulse.
module tb_ascon_round_feeder;
  import ascon_pack::*;

  typedef struct {
    logic        mode;
    bit          real_fb;
    type_state   st;
    type_state   exp;
    logic [63:0] first_s2;
    int          n;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   fb_real = 1'b0;
  int   checks = 0;
  int   errors = 0;
  type_state exp_q[$];

  ascon_round_feeder_if bus ();

  ascon_round_feeder dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0] rc_of(input int r);
    logic [7:0] v;
    v = 8'(((15 - r) << 4) | r);
    return v;
  endfunction

  // Substitution + linear diffusion of one round (constant already applied)
  function automatic type_state rnd(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  function automatic type_state sw_perm(input type_state s_in, input int n);
    type_state s;
    s = s_in;
    for (int r = 12 - n; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ rc_of(r);
      s = rnd(s);
    end
    return s;
  endfunction

  function automatic vec_t make_vec(input logic mode, input bit real_fb, input type_state st,
                                    input type_state exp, input logic [63:0] s2, input int n);
    vec_t v;
    v.mode = mode; v.real_fb = real_fb; v.st = st; v.exp = exp; v.first_s2 = s2; v.n = n;
    return v;
  endfunction

  always_comb bus.feedback_i = fb_real ? rnd(bus.state_o) : bus.state_o;

  task automatic chk320(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mon_done();
    type_state e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done actual=done_o=1 required=no pulse");
    end else begin
      e = exp_q.pop_front();
      chk320("result_at_done", bus.result_o, e);
      $display("done: result_o[2]=%h expected[2]=%h", bus.result_o[2], e[2]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) mon_done();
  end

  // One operation: start, follow the round sequence, then the done/idle tail.
  // With inj set, extra starts are pulsed mid-RUN and in the DONE cycle.
  task automatic run_op(input vec_t v, input bit inj);
    int first, busy_cnt, done_at, cyc;
    first = v.mode ? 6 : 0;
    busy_cnt = 0; done_at = 0; cyc = 1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.mode_i = v.mode; bus.state_i = v.st;
    exp_q.push_back(v.exp);
    @(negedge clk);
    bus.start_i = 1'b0; bus.mode_i = ~v.mode; bus.state_i = ~v.st;
    chk64("first_round_s2", bus.state_o[2], v.first_s2);
    while (cyc <= 40) begin
      if (bus.busy_o) begin
        chki("round_seq", int'(bus.round_o), first + busy_cnt);
        busy_cnt++;
      end
      if (bus.done_o) begin
        done_at = cyc;
        break;
      end
      bus.start_i = inj && (busy_cnt == 4);
      @(negedge clk);
      cyc++;
    end
    chki("done_latency", done_at, v.n + 1);
    chki("busy_cycles", busy_cnt, v.n);
    bus.start_i = inj;
    @(negedge clk);
    bus.start_i = 1'b0;
    chki("idle_busy", int'(bus.busy_o), 0);
    chki("done_single", int'(bus.done_o), 0);
    @(negedge clk);
    chki("no_reload", int'(bus.busy_o), 0);
    $display("op mode=%0d real=%0d inj=%0d busy=%0d done_at=%0d", v.mode, v.real_fb, inj, busy_cnt, done_at);
  endtask

  initial begin
    vec_t      tbl [4];
    type_state sa, sb, sa_p6;
    int        guard;

    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.state_i = '0;
    sa = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
          64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    sb = {64'ha71b22fa2d0f5150, 64'hb11e0a9a608e0016, 64'h076f27ad4d99d506,
          64'ha72ac1ad8440b0b7, 64'h0657b0d6eaf9c1c4};
    sa_p6 = sa;
    sa_p6[2] = 64'hbe263d4d7aecaa1e;
    tbl[0] = make_vec(1'b0, 1'b0, sa, sa,                64'hbe263d4d7aecaaff, 12);
    tbl[1] = make_vec(1'b1, 1'b0, sa, sa_p6,             64'hbe263d4d7aecaa99, 6);
    tbl[2] = make_vec(1'b0, 1'b1, sb, sw_perm(sb, 12),   64'h076f27ad4d99d5f6, 12);
    tbl[3] = make_vec(1'b1, 1'b1, sb, sw_perm(sb, 6),    64'h076f27ad4d99d590, 6);

    // Reset asserted between clock edges must take effect immediately
    #2 rst = 1'b1;
    #1;
    chki("rst_busy", int'(bus.busy_o), 0);
    chki("rst_done", int'(bus.done_o), 0);
    chki("rst_round", int'(bus.round_o), 0);
    chk320("rst_result", bus.result_o, '0);
    chk320("rst_state_o", bus.state_o, {64'h0, 64'h0, 64'h00000000000000f0, 64'h0, 64'h0});
    $display("reset: state_o[2]=%h round_o=%0d", bus.state_o[2], bus.round_o);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fb_real = tbl[i].real_fb;
      run_op(tbl[i], 1'b0);
    end

    fb_real = 1'b0;
    run_op(tbl[0], 1'b1);

    // Abort a p12 run at round 5, then a clean p6 run
    fb_real = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.state_i = sb;
    @(negedge clk);
    bus.start_i = 1'b0;
    guard = 0;
    while (bus.round_o != 4'd5 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chki("abort_at_r5", int'(bus.round_o), 5);
    rst = 1'b1;
    #1;
    chki("abort_busy", int'(bus.busy_o), 0);
    chki("abort_done", int'(bus.done_o), 0);
    chki("abort_round", int'(bus.round_o), 0);
    chk320("abort_result", bus.result_o, '0);
    chk64("abort_state_o2", bus.state_o[2], 64'h00000000000000f0);
    $display("abort: busy_o=%0d round_o=%0d", bus.busy_o, bus.round_o);
    @(negedge clk);
    rst = 1'b0;
    fb_real = 1'b0;
    run_op(tbl[1], 1'b0);

    repeat (3) @(negedge clk);
    chki("pending_results", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_round_feeder.md
# ascon_round_feeder

Sequential round-control stage sitting directly upstream of the ASCON substitution layer. Holds the 320-bit permutation state and the round counter, and applies the round-constant addition (p_C) combinationally on its output so it feeds `substitution` in the same cycle. Captures the diffusion-layer result on each clock and loops for 12 rounds (p12) or 6 rounds (p6), then presents the permuted state with a one-cycle done pulse.

## Interface
- No parameters; round counts fixed at 12 (p12) and 6 (p6); state type `type_state` (5 x 64-bit words) from `ascon_pack`.
- `clock_i` input 1: single clock, rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: start request, sampled only in IDLE.
- `mode_i` input 1: 0 = p12 (first round 0), 1 = p6 (first round 6); sampled with `start_i`.
- `state_i` input type_state: initial state, loaded on accepted start.
- `feedback_i` input type_state: output of the linear diffusion layer (end of the round combinational path).
- `state_o` output type_state: register contents with the round constant XORed in; drives the substitution input.
- `result_o` output type_state: raw register contents.
- `round_o` output 4: current round index, 0..11.
- `busy_o` output 1: high in RUN.
- `done_o` output 1: high for exactly one cycle (DONE state); `result_o` is valid in that cycle.

## Operation
- Round constant for round r: byte `((15 - r) << 4) | r`, i.e. f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b for r = 0..11.
- `state_o[k] = reg[k]` for k != 2; `state_o[2] = reg[2] ^ {56'h0, const(round_o)}`. Always active, including IDLE and DONE.
- FSM states: IDLE, RUN, DONE.
- IDLE: `start_i = 1` -> reg <= `state_i`, round <= 0 (mode 0) or 6 (mode 1), go to RUN. `start_i = 0` -> hold reg and round.
- RUN: every edge reg <= `feedback_i`. If round == 11 -> go to DONE, round holds 11; else round <= round + 1.
- DONE: reg and round hold; next edge -> IDLE. `start_i` ignored.
- `start_i` in RUN or DONE is ignored; no queuing.
- `mode_i`, `state_i` changes outside an accepted start have no effect.
- Round counter never wraps; values 12..15 are unreachable.

## Timing
- Reset (async, immediate): FSM = IDLE, reg = 0, round = 0, `busy_o` = 0, `done_o` = 0, `result_o` = 0, `state_o` = 0 except `state_o[2] = 64'h00000000000000f0`.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset values; no done pulse. Operation restarts only on a new `start_i` after release.
- Edge E0 accepts the start. The round-r constant appears on `state_o` in the cycle after E0. `feedback_i` is captured at E1..En, where n = 12 (p12) or 6 (p6).
- `done_o` is high in the cycle after En, so it asserts n+1 cycles after the accepting edge. The FSM returns to IDLE one cycle later.
- Back-to-back: the earliest next accepted start is the first IDLE edge, n+2 edges after the previous start edge.
- `busy_o` is high for exactly n cycles per operation.
- Output decode (`state_o`, `busy_o`, `done_o`) is purely from registers. There is no combinational path from `feedback_i` to any output.

## Test plan
- Reset/idle: assert `reset_i` mid-cycle -> all outputs reach reset values without a clock edge; `state_o[2] = 64'h...f0`, `round_o = 0`.
- p12 identity loop (bench ties `feedback_i = state_o`), `state_i` = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}:
  - first RUN cycle: `state_o[2] = be263d4d7aecaaff`;
  - `round_o` steps 0..11; `busy_o` is high for 12 cycles;
  - `done_o` pulses once, with `result_o` equal to `state_i` (the XOR of all 12 constants is 0).
- p6 identity loop, same `state_i`, `mode_i = 1` -> `round_o` steps 6..11, `busy_o` is high for 6 cycles, `result_o[2] = be263d4d7aecaa1e`, and the other words are unchanged.
- Real round: bench model computes substitution + diffusion on `state_o`. Use `state_i` = {a71b22fa2d0f5150, b11e0a9a608e0016, 076f27ad4d99d506, a72ac1ad8440b0b7, 0657b0d6eaf9c1c4}, p12 -> `result_o` matches the software ASCON p12 reference at the `done_o` cycle.
- Ignored start: pulse `start_i` with a different `state_i` during RUN and during DONE -> no reload, round sequence undisturbed, a single `done_o` pulse.
- Abort: assert `reset_i` at `round_o = 5` of p12, release, start p6 -> clean p6 run, no stale `done_o`.
